conv2d_stream: RTL and testbench
================================

Name: conv2d_stream

Overview:
- Parametrised streaming 2-D convolution engine: next generation of the fixed Conv2D block.
- Started by en_conv2d and signals done, as before, but adds the following:
  - generic image, kernel and data sizes;
  - a loadable kernel-weight register file;
  - valid/ready pixel input and result output with backpressure;
  - optional ReLU.
- Computes a "valid" (no padding, stride 1) convolution of one IMG_H x IMG_W frame per run; sits between the pixel source and the pooling/activation stage.

Parameters:
DATA_W, 8, width of signed two's-complement pixels and weights
IMG_W, 8, frame width in pixels (>= K)
IMG_H, 8, frame height in pixels (>= K)
K, 3, kernel side length (odd, >= 1)
RELU, 0, 1 = clamp negative results to 0 at the output
ACC_W, 2*DATA_W+$clog2(K*K), signed accumulator/result width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en_conv2d  input  1  start request, sampled in IDLE only
w_we  input  1  weight write strobe, honoured in IDLE only
w_addr  input  $clog2(K*K)  weight index, row-major (r*K+c)
w_data  input  DATA_W  signed weight value
pix_valid  input  1  pixel present on pix_data
pix_data  input  DATA_W  signed pixel, raster order
pix_ready  output  1  engine accepts pixel this cycle
out_valid  output  1  out_data holds a result
out_data  output  ACC_W  signed convolution result, raster order
out_ready  input  1  downstream accepts result
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE. All weights go to 0. Line buffers, window and counters go to 0.
  - pix_ready=0, out_valid=0, out_data=0, busy=0, done=0.
  - Reset asserted mid-frame aborts the frame with no done pulse.
- States:
  - IDLE --en_conv2d=1--> RUN.
  - RUN --last pixel accepted--> DRAIN.
  - DRAIN --out_valid=0, or final result handshaken--> DONE.
  - DONE --next cycle--> IDLE.
  - done=1 only in the cycle the FSM is in DONE.
- Weights: a write is w[w_addr] <= w_data on posedge when w_we=1 and state==IDLE. Writes in any other state are ignored. Weights persist across frames.
- Entry to RUN clears the row counter, column counter and output count.
- en_conv2d outside IDLE is ignored.
- Input handshake:
  - pix_ready = (state==RUN) && (!out_valid || out_ready).
  - A pixel is accepted when pix_valid && pix_ready.
  - The column counter advances 0..IMG_W-1 and wraps, incrementing the row counter 0..IMG_H-1.
- Storage: K-1 line buffers of IMG_W entries plus a KxK window shift register, updated only on acceptance.
- Window completion: the accepted pixel at (row, col) completes a window when row >= K-1 and col >= K-1.
- Result timing:
  - Latency is 1 cycle. out_valid rises on the clock edge after acceptance, with out_data = sum over r,c of w[r*K+c]*p[row-K+1+r][col-K+1+c], computed at full ACC_W precision with no saturation.
  - If RELU=1 and the sum is < 0, out_data = 0.
- Output handshake:
  - out_valid/out_data are held stable until out_valid && out_ready.
  - A new result is loaded in the same cycle that the old one drains (simultaneous pop and push allowed).
  - out_valid falls only when the result drains with no new result arriving.
- Frame size: exactly (IMG_H-K+1)*(IMG_W-K+1) results per frame.
- Column wrap: a row wrap never produces a window spanning two rows. The column index guards this; the shift-register contents are stale and unused.
- End of frame: after the pixel at (IMG_H-1, IMG_W-1) is accepted, pix_ready drops. The FSM goes to DONE once the final result's out_valid && out_ready occurs.
- Degenerate case K=1: every pixel yields a result, equal to w[0]*pixel.

Test Plan:
- Ramp, all-ones kernel: K=3, IMG 4x4, all 9 weights=1, pixels 1..16, pix_valid and out_ready held 1 -> outputs 54,63,90,99 in order; done pulses once, 1 cycle after the last result handshake; busy then drops.
- Identity kernel: w[4]=1, others 0, same frame -> outputs 6,7,10,11.
- Backpressure: out_ready toggled 1,0,0,1 repeatedly, random pix_valid gaps -> identical value sequence 54,63,90,99; out_data stable while out_valid && !out_ready; pix_ready=0 whenever out_valid && !out_ready.
- Negative kernel and ReLU: all weights=-1 (0xFF) -> RELU=0 gives -54,-63,-90,-99; RELU=1 gives 0,0,0,0.
- Protocol guards: w_we pulses during RUN (w_data=5) are ignored, so results are unchanged; en_conv2d pulses during RUN start no second frame; two back-to-back frames each give 4 results and 2 done pulses.
- Reset mid-frame: rst_n=0 after pixel 9 -> outputs at reset values immediately, all weights read back 0 (next frame with no reload gives 0,0,0,0), no done pulse.

Source files
------------

// File: rtl/conv2d_stream.sv
// conv2d_stream: streaming "valid" 2-D convolution (stride 1, no padding)
// over one IMG_H x IMG_W frame of signed pixels per run.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   en_conv2d           start request, sampled in IDLE only
//   w_we/w_addr/w_data  kernel weight write (row-major r*K+c), IDLE only
//   pix_valid/pix_data  pixel input stream, raster order
//   pix_ready           engine accepts a pixel this cycle
//   out_valid/out_data  result output stream, raster order
//   out_ready           downstream accepts the result
//   busy                high in RUN and DRAIN
//   done                one-cycle pulse in the DONE state
//
// Handshake semantics (both streams): a transfer happens on the rising edge
// where valid && ready are both high. The producer holds valid and data
// stable until that edge; ready may depend combinationally on the consumer's
// own ready (pix_ready follows out_ready) but valid never depends on ready.
module conv2d_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int RELU   = 0,
  parameter int ACC_W  = 2*DATA_W+$clog2(K*K)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  en_conv2d,
  input  logic                                  w_we,
  input  logic [((K>1)?$clog2(K*K):1)-1:0]      w_addr,
  input  logic signed [DATA_W-1:0]              w_data,
  input  logic                                  pix_valid,
  input  logic signed [DATA_W-1:0]              pix_data,
  output logic                                  pix_ready,
  output logic                                  out_valid,
  output logic signed [ACC_W-1:0]               out_data,
  input  logic                                  out_ready,
  output logic                                  busy,
  output logic                                  done
);

  localparam int NW   = K*K;
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_N = (K > 1) ? K-1 : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // state is kept as a plain named register so checkers can bind to it
  state_t state, state_nxt;

  logic signed [DATA_W-1:0] wt     [NW];
  logic signed [DATA_W-1:0] win    [K][K];
  logic signed [DATA_W-1:0] nwin   [K][K];
  logic signed [DATA_W-1:0] newcol [K];
  logic signed [DATA_W-1:0] lb_col [LB_N];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  res;

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;

  logic accept;
  logic last_pix;
  logic win_done;
  logic start;

  assign start    = (state == S_IDLE) && en_conv2d;
  assign accept   = pix_valid && pix_ready;
  assign last_pix = (int'(row_cnt) == IMG_H-1) && (int'(col_cnt) == IMG_W-1);
  // the column guard keeps windows from straddling a row wrap
  assign win_done = accept && (int'(row_cnt) >= K-1) && (int'(col_cnt) >= K-1);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (en_conv2d)          state_nxt = S_RUN;
      S_RUN:   if (accept && last_pix) state_nxt = S_DRAIN;
      S_DRAIN: if (!out_valid || out_ready) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    pix_ready = (state == S_RUN) && (!out_valid || out_ready);
    busy      = (state == S_RUN) || (state == S_DRAIN);
    done      = (state == S_DONE);
  end

  // ---------------- weights ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) wt[i] <= '0;
    end else if ((state == S_IDLE) && w_we && (int'(w_addr) < NW)) begin
      wt[w_addr] <= w_data;
    end
  end

  // ---------------- raster counters ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (start) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      if (int'(col_cnt) == IMG_W-1) begin
        col_cnt <= '0;
        row_cnt <= (int'(row_cnt) == IMG_H-1) ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // ---------------- line buffers ----------------
  // lb[j][col] holds the pixel of row (row - (K-1) + j) at this column, so
  // reading the current column gives the K-1 rows above the incoming pixel.
  if (K > 1) begin : g_lb
    logic signed [DATA_W-1:0] lb [K-1][IMG_W];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < K-1; j++)
          for (int x = 0; x < IMG_W; x++) lb[j][x] <= '0;
      end else if (accept) begin
        for (int j = 0; j < K-2; j++) lb[j][col_cnt] <= lb[j+1][col_cnt];
        lb[K-2][col_cnt] <= pix_data;
      end
    end

    always_comb begin
      for (int j = 0; j < K-1; j++) lb_col[j] = lb[j][col_cnt];
    end
  end else begin : g_nolb
    always_comb begin
      for (int j = 0; j < LB_N; j++) lb_col[j] = '0;
    end
  end

  // ---------------- window and MAC ----------------
  // The sum is taken over the window as it will be after this acceptance,
  // so the result registers on the same edge that shifts the window.
  always_comb begin
    for (int r = 0; r < K-1; r++) newcol[r] = lb_col[r];
    newcol[K-1] = pix_data;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K-1; c++) nwin[r][c] = win[r][c+1];
      nwin[r][K-1] = newcol[r];
    end
    acc = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        acc = acc + ACC_W'(wt[r*K+c]) * ACC_W'(nwin[r][c]);
    res = ((RELU != 0) && acc[ACC_W-1]) ? '0 : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win[r][c] <= nwin[r][c];
    end
  end

  // ---------------- output register ----------------
  // A new result may load in the same cycle the old one drains; pix_ready
  // already guarantees the slot is free or emptying when win_done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (win_done) begin
      out_valid <= 1'b1;
      out_data  <= res;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
module tb_conv2d_stream;

  localparam int DW = 8;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int KK = 3;
  localparam int AW = 2*DW + $clog2(KK*KK);
  localparam int NPIX = IW*IH;

  logic clk = 1'b0;
  logic rst_n;
  logic en_conv2d;
  logic w_we;
  logic [3:0] w_addr;
  logic signed [DW-1:0] w_data;
  logic pix_valid;
  logic signed [DW-1:0] pix_data;
  logic out_ready;

  logic pix_ready, out_valid, busy, done;
  logic signed [AW-1:0] out_data;
  logic pix_ready_r, out_valid_r, busy_r, done_r;
  logic signed [AW-1:0] out_data_r;

  int total = 0;
  int bad = 0;

  // reference model state
  int img [NPIX];
  int wt  [KK*KK];
  logic signed [AW-1:0] exp_q [$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  conv2d_stream #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .K(KK), .RELU(0)) dut (
    .clk(clk), .rst_n(rst_n), .en_conv2d(en_conv2d), .w_we(w_we),
    .w_addr(w_addr), .w_data(w_data), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .busy(busy), .done(done)
  );

  conv2d_stream #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .K(KK), .RELU(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .en_conv2d(en_conv2d), .w_we(w_we),
    .w_addr(w_addr), .w_data(w_data), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready_r), .out_valid(out_valid_r),
    .out_data(out_data_r), .out_ready(out_ready), .busy(busy_r), .done(done_r)
  );

  // ---------------- model ----------------
  // Expected results: direct sum over each output position of the frame.
  function automatic void build_exp();
    int s;
    exp_q.delete();
    for (int orow = 0; orow <= IH-KK; orow++)
      for (int ocol = 0; ocol <= IW-KK; ocol++) begin
        s = 0;
        for (int r = 0; r < KK; r++)
          for (int c = 0; c < KK; c++)
            s += wt[r*KK+c] * img[(orow+r)*IW + ocol + c];
        exp_q.push_back(AW'(s));
      end
  endfunction

  function automatic logic signed [AW-1:0] relu(input logic signed [AW-1:0] v);
    return (v < 0) ? '0 : v;
  endfunction

  function automatic void set_ramp();
    for (int i = 0; i < NPIX; i++) img[i] = i + 1;
  endfunction

  function automatic void set_kernel(input int v);
    for (int i = 0; i < KK*KK; i++) wt[i] = v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_weights();
    for (int i = 0; i < KK*KK; i++) begin
      @(negedge clk);
      w_we   = 1'b1;
      w_addr = 4'(i);
      w_data = DW'(wt[i]);
    end
    @(negedge clk);
    w_we = 1'b0;
  endtask

  // Runs one frame: gaps=1 inserts random pix_valid holes, bp selects the
  // out_ready pattern (0 always, 1 = 1,0,0,1, 2 random), guard=1 sprays
  // en_conv2d and weight writes while the frame is running.
  task automatic run_frame(input int gaps, input int bp, input int guard,
                           output int nres, output int ndone);
    int pi, last_hs, cyc;
    bit fin, hold;
    logic signed [AW-1:0] held, e;
    nres = 0; ndone = 0; pi = 0; last_hs = -10; fin = 0; hold = 0; held = '0;
    @(negedge clk);
    en_conv2d = 1'b1;
    @(negedge clk);
    en_conv2d = 1'b0;
    for (cyc = 0; cyc < 1000 && !fin; cyc++) begin
      pix_valid = (pi < NPIX) && (gaps == 0 || $urandom_range(0, 2) != 0);
      if (pi < NPIX) pix_data = DW'(img[pi]);
      else           pix_data = '0;
      if (bp == 0)      out_ready = 1'b1;
      else if (bp == 1) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      else              out_ready = 1'($urandom_range(0, 1));
      if (guard != 0) begin
        en_conv2d = 1'($urandom_range(0, 1));
        w_we      = 1'($urandom_range(0, 1));
        w_addr    = 4'($urandom_range(0, KK*KK-1));
        w_data    = 8'd5;
      end
      #1;
      if (hold) begin
        total++;
        if (!out_valid || out_data !== held) begin
          bad++;
          $display("FAIL hold_stable: out_valid=%0b out_data=%0d required %0d held", out_valid, out_data, held);
        end
      end
      if (out_valid && !out_ready) begin
        total++;
        if (pix_ready !== 1'b0) begin
          bad++;
          $display("FAIL stall_ready: pix_ready=%0b required 0 under backpressure", pix_ready);
        end
      end
      total++;
      if (pix_ready !== pix_ready_r || out_valid !== out_valid_r) begin
        bad++;
        $display("FAIL lockstep: ready %0b/%0b valid %0b/%0b", pix_ready, pix_ready_r, out_valid, out_valid_r);
      end
      if (done) begin
        ndone++;
        fin = 1;
        total++;
        if (cyc != last_hs + 1 || exp_q.size() != 0) begin
          bad++;
          $display("FAIL done_timing: done at cycle %0d, last handshake %0d, %0d results outstanding", cyc, last_hs, exp_q.size());
        end
      end else begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL busy_run: busy=%0b required 1 at cycle %0d", busy, cyc);
        end
      end
      if (out_valid && out_ready) begin
        nres++;
        last_hs = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_result: got %0d, none required", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            bad++;
            $display("FAIL result: out_data=%0d required %0d", out_data, e);
          end
          total++;
          if (out_data_r !== relu(e)) begin
            bad++;
            $display("FAIL relu_result: out_data=%0d required %0d", out_data_r, relu(e));
          end
        end
      end
      hold = out_valid && !out_ready;
      held = out_data;
      if (pix_valid && pix_ready) pi++;
      if (fin) begin
        pix_valid = 1'b0;
        en_conv2d = 1'b0;
        w_we      = 1'b0;
      end
      @(negedge clk);
    end
    total++;
    if (!fin) begin
      bad++;
      $display("FAIL frame_timeout: no done within 1000 cycles, %0d results", nres);
    end else begin
      #1;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL post_done: done=%0b busy=%0b required 0/0", done, busy);
      end
    end
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; en_conv2d = 0; w_we = 0; w_addr = '0; w_data = '0;
    pix_valid = 0; pix_data = '0; out_ready = 0;
    #1;
    total++;
    if (pix_ready !== 0 || out_valid !== 0 || busy !== 0 || done !== 0) begin
      bad++;
      $display("FAIL reset_ctrl: ready=%0b valid=%0b busy=%0b done=%0b required 0", pix_ready, out_valid, busy, done);
    end
    total++;
    if (out_data !== '0 || out_data_r !== '0) begin
      bad++;
      $display("FAIL reset_data: out_data=%0d/%0d required 0", out_data, out_data_r);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_frame(input string name, input int nres, input int ndone, input int want);
    total++;
    if (nres != want || ndone != 1) begin
      bad++;
      $display("FAIL %s: results=%0d done=%0d required %0d/1", name, nres, ndone, want);
    end
  endtask

  task automatic test_ramp_ones();
    int n, d;
    set_ramp(); set_kernel(1); load_weights(); build_exp();
    run_frame(0, 0, 0, n, d);
    check_frame("ramp_ones", n, d, 4);
  endtask

  task automatic test_identity();
    int n, d;
    set_ramp(); set_kernel(0); wt[4] = 1; load_weights(); build_exp();
    run_frame(0, 0, 0, n, d);
    check_frame("identity", n, d, 4);
  endtask

  task automatic test_backpressure();
    int n, d;
    set_ramp(); set_kernel(1); load_weights();
    build_exp(); run_frame(1, 1, 0, n, d); check_frame("bp_pattern", n, d, 4);
    build_exp(); run_frame(1, 2, 0, n, d); check_frame("bp_random", n, d, 4);
  endtask

  task automatic test_negative();
    int n, d;
    set_ramp(); set_kernel(-1); load_weights(); build_exp();
    run_frame(0, 0, 0, n, d);
    check_frame("negative", n, d, 4);
  endtask

  task automatic test_guards();
    int n, d;
    set_ramp(); set_kernel(1); load_weights();
    build_exp(); run_frame(0, 2, 1, n, d); check_frame("guard_run", n, d, 4);
    build_exp(); run_frame(0, 0, 0, n, d); check_frame("guard_after", n, d, 4);
  endtask

  task automatic test_back_to_back();
    int n1, d1, n2, d2;
    for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 255) - 128;
    set_kernel(2); load_weights();
    build_exp(); run_frame(0, 0, 0, n1, d1);
    for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 255) - 128;
    build_exp(); run_frame(0, 0, 0, n2, d2);
    total++;
    if (n1 + n2 != 8 || d1 + d2 != 2) begin
      bad++;
      $display("FAIL back_to_back: results=%0d done=%0d required 8/2", n1 + n2, d1 + d2);
    end
  endtask

  task automatic test_random();
    int n, d;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < NPIX; i++) img[i] = $urandom_range(0, 255) - 128;
      for (int i = 0; i < KK*KK; i++) wt[i] = $urandom_range(0, 255) - 128;
      load_weights(); build_exp();
      run_frame(1, 2, 0, n, d);
      check_frame("random", n, d, 4);
    end
  endtask

  task automatic test_reset_mid();
    int acc, n, d, cyc;
    bit saw_done;
    set_ramp(); set_kernel(1); load_weights();
    acc = 0; saw_done = 0;
    @(negedge clk); en_conv2d = 1'b1;
    @(negedge clk); en_conv2d = 1'b0; out_ready = 1'b1;
    for (cyc = 0; cyc < 100 && acc < 9; cyc++) begin
      pix_valid = 1'b1;
      pix_data  = DW'(img[acc]);
      #1;
      if (done) saw_done = 1;
      if (pix_ready) acc++;
      @(negedge clk);
    end
    pix_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (pix_ready !== 0 || out_valid !== 0 || out_data !== '0 || busy !== 0 || done !== 0 || saw_done || acc != 9) begin
      bad++;
      $display("FAIL reset_mid: ready=%0b valid=%0b data=%0d busy=%0b done=%0b saw_done=%0b accepted=%0d",
               pix_ready, out_valid, out_data, busy, done, saw_done, acc);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_kernel(0); build_exp();
    run_frame(0, 0, 0, n, d);
    check_frame("reset_weights", n, d, 4);
  endtask

  initial begin
    test_reset();
    test_ramp_ones();
    test_identity();
    test_backpressure();
    test_negative();
    test_guards();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
